// File: rtl/seg_scan_if.sv
// Write/commit port for the seven-segment scan scheduler.
// A write or commit transfers on any rising edge where the request (wr_valid or commit) and wr_ready are both high;
// requests may be held while wr_ready is low, and nothing is taken on those cycles.
interface seg_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       commit;

  modport master (output wr_valid, wr_addr, wr_data, wr_dp, commit, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_dp, commit, output wr_ready);
endinterface

// File: rtl/seg_scan_scheduler.sv
// Round-robin scanner for an 8-digit common-anode display.
// A shadow buffer is copied to the displayed buffer only at frame boundaries.
module seg_scan_scheduler #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_if.slave       wr,
  input  logic [7:0]      digit_en,
  output logic [7:0]      an,
  output logic [6:0]      seg,
  output logic            dp,
  output logic            frame_start,
  output logic            scan_state
);
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    cur, cur_nx;
  logic          first, first_nx;
  logic          pending;
  logic [4:0]    shadow [8];
  logic [4:0]    active [8];

  logic       last, select, new_frame, copy, sel_found;
  logic [2:0] sel_idx;
  logic [4:0] disp;
  logic       wr_fire, commit_fire;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign wr.wr_ready  = !rst && !pending;
  assign wr_fire      = wr.wr_valid && wr.wr_ready;
  assign commit_fire  = wr.commit && wr.wr_ready;
  assign scan_state   = (state == SHOW);

  // Lowest enabled index overall, then overridden by the lowest one above cur if any.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (digit_en[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      if (digit_en[i] && (3'(i) > cur)) sel_idx = 3'(i);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - CW'(1);
    cur_nx   = cur;
    first_nx = first;
    select   = 1'b0;
    last     = (cnt == CW'(1));
    case (state)
      BLANK: begin
        if (last) begin
          if (sel_found) begin
            state_nx = SHOW;
            cnt_nx   = CW'(DIGIT_CYCLES);
            cur_nx   = sel_idx;
            first_nx = 1'b0;
            select   = 1'b1;
          end else begin
            cnt_nx   = CW'(BLANK_CYCLES);
            first_nx = 1'b1;
          end
        end
      end
      SHOW: begin
        if (last) begin
          state_nx = BLANK;
          cnt_nx   = CW'(BLANK_CYCLES);
        end
      end
      default: state_nx = BLANK;
    endcase
    new_frame = select && (first || (sel_idx <= cur));
    copy      = pending && (new_frame || (digit_en == 8'h00));
    disp      = copy ? shadow[sel_idx] : active[sel_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= CW'(BLANK_CYCLES);
      cur         <= 3'd7;
      first       <= 1'b1;
      pending     <= 1'b0;
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      cur         <= cur_nx;
      first       <= first_nx;
      frame_start <= new_frame;
      if (wr_fire) shadow[wr.wr_addr] <= {wr.wr_dp, wr.wr_data};
      // copy and commit_fire are exclusive: a pending commit holds wr_ready low
      if (copy) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
        pending <= 1'b0;
      end else if (commit_fire) begin
        pending <= 1'b1;
      end
      if (select) begin
        an  <= ~(8'b1 << sel_idx);
        seg <= decode(disp[3:0]);
        dp  <= ~disp[4];
      end else if (state == SHOW && last) begin
        an  <= 8'hFF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end
endmodule
